// File: rtl/hazard_pkg.sv
// Shared types and constants for the RAT CPU pipeline hazard unit.
package hazard_pkg;

    localparam int unsigned WB_AW = 5;
    localparam logic [1:0]  RF_SEL_SCR = 2'b01;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH      = 2'd1,
        INT_DRAIN  = 2'd2,
        INT_INJECT = 2'd3
    } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// Decode/EX hazard inputs and bubble/interrupt controls exchanged with the hazard unit.
interface pipeline_hazard_unit_if #(
    parameter int unsigned WB_AW = hazard_pkg::WB_AW
);
    logic             dec_valid;
    logic             dec_uses_x;
    logic             dec_uses_y;
    logic [WB_AW-1:0] dec_x_addr;
    logic [WB_AW-1:0] dec_y_addr;
    logic             ex_RF_WR;
    logic [1:0]       ex_RF_WR_SEL;
    logic [WB_AW-1:0] ex_WB_ADDR;
    logic             ex_branch_taken;
    logic             intr_req;
    logic             i_flag;
    logic             nop;
    logic             interupt;
    logic             pc_stall;
    logic             intr_ack;

    // Pipeline side: supplies stage status, consumes the controls.
    modport master (
        output dec_valid, dec_uses_x, dec_uses_y, dec_x_addr, dec_y_addr,
        output ex_RF_WR, ex_RF_WR_SEL, ex_WB_ADDR, ex_branch_taken,
        output intr_req, i_flag,
        input  nop, interupt, pc_stall, intr_ack
    );

    // Hazard unit side.
    modport slave (
        input  dec_valid, dec_uses_x, dec_uses_y, dec_x_addr, dec_y_addr,
        input  ex_RF_WR, ex_RF_WR_SEL, ex_WB_ADDR, ex_branch_taken,
        input  intr_req, i_flag,
        output nop, interupt, pc_stall, intr_ack
    );

endinterface

// File: rtl/hazard_cmp.sv
// Load-use detector: a scratch-RAM load in EX whose destination feeds a decode operand.
module hazard_cmp #(
    parameter int unsigned WB_AW = hazard_pkg::WB_AW
) (
    input  logic             ex_rf_wr,
    input  logic [1:0]       ex_rf_wr_sel,
    input  logic [WB_AW-1:0] ex_wb_addr,
    input  logic             dec_valid,
    input  logic             dec_uses_x,
    input  logic [WB_AW-1:0] dec_x_addr,
    input  logic             dec_uses_y,
    input  logic [WB_AW-1:0] dec_y_addr,
    output logic             load_use_c
);
    import hazard_pkg::*;

    logic ex_is_load_c;
    logic x_hit_c;
    logic y_hit_c;

    assign ex_is_load_c = ex_rf_wr && (ex_rf_wr_sel == RF_SEL_SCR);
    assign x_hit_c      = dec_uses_x && (dec_x_addr == ex_wb_addr);
    assign y_hit_c      = dec_uses_y && (dec_y_addr == ex_wb_addr);
    assign load_use_c   = ex_is_load_c && dec_valid && (x_hit_c || y_hit_c);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Bubble, stall and interrupt-injection sequencer feeding control_vector_reg.
module pipeline_hazard_unit #(
    parameter int unsigned BRANCH_BUBBLES = 2,
    parameter int unsigned DRAIN_CYCLES   = 2,
    parameter int unsigned WB_AW          = hazard_pkg::WB_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_unit_if.slave hz
);
    import hazard_pkg::*;

    localparam int unsigned CNT_MAX = (BRANCH_BUBBLES > DRAIN_CYCLES) ? BRANCH_BUBBLES
                                                                      : DRAIN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] BR_RELOAD  = CNT_W'(BRANCH_BUBBLES - 1);
    localparam logic [CNT_W-1:0] BR_POST    = CNT_W'(BRANCH_BUBBLES);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    hz_state_t        state;
    hz_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic load_use_c;
    logic nop_c;
    logic interupt_c;
    logic pc_stall_c;
    logic intr_ack_c;

    hazard_cmp #(
        .WB_AW (WB_AW)
    ) u_cmp (
        .ex_rf_wr     (hz.ex_RF_WR),
        .ex_rf_wr_sel (hz.ex_RF_WR_SEL),
        .ex_wb_addr   (hz.ex_WB_ADDR),
        .dec_valid    (hz.dec_valid),
        .dec_uses_x   (hz.dec_uses_x),
        .dec_x_addr   (hz.dec_x_addr),
        .dec_uses_y   (hz.dec_uses_y),
        .dec_y_addr   (hz.dec_y_addr),
        .load_use_c   (load_use_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, bubble counter and per-cycle controls.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        nop_c      = 1'b0;
        interupt_c = 1'b0;
        pc_stall_c = 1'b0;
        intr_ack_c = 1'b0;

        case (state)
            RUN: begin
                if (hz.ex_branch_taken) begin
                    nop_c = 1'b1;
                    if (BRANCH_BUBBLES > 1) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = BR_RELOAD;
                    end
                end else if (load_use_c) begin
                    nop_c      = 1'b1;
                    pc_stall_c = 1'b1;
                end else if (hz.intr_req && hz.i_flag) begin
                    // Current instruction proceeds; draining starts next cycle.
                    state_nxt = INT_DRAIN;
                    cnt_nxt   = DRAIN_LOAD;
                end
            end

            FLUSH: begin
                nop_c = 1'b1;
                if (hz.ex_branch_taken) begin
                    if (BRANCH_BUBBLES > 1) begin
                        cnt_nxt = BR_RELOAD;
                    end else begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt <= CNT_ONE) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end
                end
            end

            INT_DRAIN: begin
                // Entry is committed: branches and a dropped request are ignored here.
                nop_c      = 1'b1;
                pc_stall_c = 1'b1;
                cnt_nxt    = cnt - CNT_ONE;
                if (cnt <= CNT_ONE) begin
                    state_nxt = INT_INJECT;
                    cnt_nxt   = '0;
                end
            end

            INT_INJECT: begin
                interupt_c = 1'b1;
                intr_ack_c = 1'b1;
                pc_stall_c = 1'b1;
                if (BRANCH_BUBBLES == 0) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = FLUSH;
                    cnt_nxt   = BR_POST;
                end
            end

            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Reset forces every control low immediately, without waiting for a clock.
    assign hz.nop      = nop_c      & rst_n;
    assign hz.interupt = interupt_c & rst_n;
    assign hz.pc_stall = pc_stall_c & rst_n;
    assign hz.intr_ack = intr_ack_c & rst_n;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: vector table, directed corner sequences, random vs timeline model.
module tb_pipeline_hazard_unit;

    localparam int BB    = 2;
    localparam int DC    = 2;
    localparam int AW    = 5;
    localparam int NRAND = 700;
    localparam int MLEN  = NRAND + BB + DC + 8;

    typedef struct packed {
        logic          dv;
        logic          ux;
        logic          uy;
        logic [AW-1:0] xa;
        logic [AW-1:0] ya;
        logic          wr;
        logic [1:0]    sel;
        logic [AW-1:0] wa;
        logic          br;
        logic          irq;
        logic          ifl;
    } stim_t;

    typedef struct {
        stim_t s;
        logic  e_nop;
        logic  e_stall;
        logic  e_nop_next;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit_if #(.WB_AW(AW)) hz ();

    pipeline_hazard_unit #(
        .BRANCH_BUBBLES (BB),
        .DRAIN_CYCLES   (DC),
        .WB_AW          (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    function automatic stim_t mk(input logic dv, input logic ux, input logic uy,
                                 input logic [AW-1:0] xa, input logic [AW-1:0] ya,
                                 input logic wr, input logic [1:0] sel, input logic [AW-1:0] wa,
                                 input logic br, input logic irq, input logic ifl);
        stim_t s;
        s.dv = dv; s.ux = ux; s.uy = uy; s.xa = xa; s.ya = ya;
        s.wr = wr; s.sel = sel; s.wa = wa; s.br = br; s.irq = irq; s.ifl = ifl;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        hz.dec_valid       = s.dv;
        hz.dec_uses_x      = s.ux;
        hz.dec_uses_y      = s.uy;
        hz.dec_x_addr      = s.xa;
        hz.dec_y_addr      = s.ya;
        hz.ex_RF_WR        = s.wr;
        hz.ex_RF_WR_SEL    = s.sel;
        hz.ex_WB_ADDR      = s.wa;
        hz.ex_branch_taken = s.br;
        hz.intr_req        = s.irq;
        hz.i_flag          = s.ifl;
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk4(input string nm, input logic en, input logic es, input logic ei);
        chk({nm, ".nop"},      hz.nop,      en);
        chk({nm, ".pc_stall"}, hz.pc_stall, es);
        chk({nm, ".interupt"}, hz.interupt, ei);
        chk({nm, ".intr_ack"}, hz.intr_ack, ei);
    endtask

    // Drive one cycle's inputs, check mid-cycle, then move just past the next rising edge.
    task automatic cyc_chk(input string nm, input stim_t s,
                           input logic en, input logic es, input logic ei);
        apply(s);
        @(negedge clk);
        chk4(nm, en, es, ei);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            apply('0);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic load_use(input stim_t s);
        return s.wr && s.sel == 2'b01 && s.dv &&
               ((s.ux && s.xa == s.wa) || (s.uy && s.ya == s.wa));
    endfunction

    // Timeline model: each accepted event writes its future output pattern into per-cycle arrays.
    bit m_nop   [MLEN];
    bit m_stall [MLEN];
    bit m_int   [MLEN];
    int busy_end;
    int lock_end;

    task automatic mark_nop(input int from, input int upto);
        for (int c = from; c <= upto; c++) if (c < MLEN) m_nop[c] = 1'b1;
    endtask

    task automatic model_step(input int k, input stim_t s, input bit in_rst);
        if (in_rst) begin
            for (int c = k; c < MLEN; c++) begin
                m_nop[c] = 1'b0; m_stall[c] = 1'b0; m_int[c] = 1'b0;
            end
            busy_end = k;
            lock_end = k;
        end else if (k > busy_end) begin
            if (s.br) begin
                mark_nop(k, k + BB - 1);
                busy_end = k + BB - 1;
            end else if (load_use(s)) begin
                m_nop[k]   = 1'b1;
                m_stall[k] = 1'b1;
            end else if (s.irq && s.ifl) begin
                mark_nop(k + 1, k + DC);
                for (int c = k + 1; c <= k + DC + 1; c++) m_stall[c] = 1'b1;
                m_int[k + DC + 1] = 1'b1;
                mark_nop(k + DC + 2, k + DC + 1 + BB);
                lock_end = k + DC + 1;
                busy_end = k + DC + 1 + BB;
            end
        end else if (k > lock_end && s.br) begin
            mark_nop(k, k + BB - 1);
            busy_end = k + BB - 1;
        end
    endtask

    vec_t  vt [11];
    stim_t idle_s, br_s, irq_s, combo_s, s;
    bit    do_rst;

    initial begin
        idle_s  = '0;
        br_s    = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        irq_s   = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1);
        combo_s = mk(1, 1, 0, 3, 0, 1, 2'b01, 3, 1, 1, 1);

        vt[0]  = '{mk(1, 1, 0, 3, 0, 1, 2'b01, 3, 0, 0, 0), 1, 1, 0};
        vt[1]  = '{mk(1, 1, 0, 4, 0, 1, 2'b01, 3, 0, 0, 0), 0, 0, 0};
        vt[2]  = '{mk(1, 0, 1, 0, 7, 1, 2'b01, 7, 0, 0, 0), 1, 1, 0};
        vt[3]  = '{mk(1, 0, 0, 0, 7, 1, 2'b01, 7, 0, 0, 0), 0, 0, 0};
        vt[4]  = '{mk(0, 1, 0, 3, 0, 1, 2'b01, 3, 0, 0, 0), 0, 0, 0};
        vt[5]  = '{mk(1, 1, 0, 3, 0, 1, 2'b00, 3, 0, 0, 0), 0, 0, 0};
        vt[6]  = '{mk(1, 1, 0, 3, 0, 0, 2'b01, 3, 0, 0, 0), 0, 0, 0};
        vt[7]  = '{mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0), 1, 0, 1};
        vt[8]  = '{mk(1, 1, 1, 9, 9, 1, 2'b01, 9, 1, 0, 0), 1, 0, 1};
        vt[9]  = '{mk(1, 1, 0, 3, 0, 1, 2'b10, 3, 0, 0, 0), 0, 0, 0};
        vt[10] = '{mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0), 0, 0, 0};

        // Reset: outputs forced low even with every trigger asserted.
        rst_n = 1'b0;
        apply(combo_s);
        #2;
        chk4("rst_async", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk4("rst_held", 1'b0, 1'b0, 1'b0);
        apply(idle_s);
        rst_n = 1'b1;
        idle_cycles(2);

        for (int i = 0; i < 11; i++) begin
            apply(vt[i].s);
            @(negedge clk);
            chk($sformatf("vec%0d.nop", i), hz.nop, vt[i].e_nop);
            chk($sformatf("vec%0d.pc_stall", i), hz.pc_stall, vt[i].e_stall);
            chk($sformatf("vec%0d.interupt", i), hz.interupt, 1'b0);
            @(posedge clk);
            #1;
            apply(idle_s);
            @(negedge clk);
            chk($sformatf("vec%0d.nop_next", i), hz.nop, vt[i].e_nop_next);
            chk($sformatf("vec%0d.stall_next", i), hz.pc_stall, 1'b0);
            @(posedge clk);
            #1;
            idle_cycles(3);
        end

        // Single branch.
        cyc_chk("br_t0", br_s,   1, 0, 0);
        cyc_chk("br_t1", idle_s, 1, 0, 0);
        cyc_chk("br_t2", idle_s, 0, 0, 0);
        idle_cycles(2);

        // Second branch inside the flush window.
        cyc_chk("brbr_t0", br_s,   1, 0, 0);
        cyc_chk("brbr_t1", br_s,   1, 0, 0);
        cyc_chk("brbr_t2", idle_s, 1, 0, 0);
        cyc_chk("brbr_t3", idle_s, 0, 0, 0);
        idle_cycles(2);

        // Interrupt entry; request drops right after being sampled.
        cyc_chk("int_t0", irq_s,  0, 0, 0);
        cyc_chk("int_t1", idle_s, 1, 1, 0);
        cyc_chk("int_t2", idle_s, 1, 1, 0);
        cyc_chk("int_t3", idle_s, 0, 1, 1);
        cyc_chk("int_t4", idle_s, 1, 0, 0);
        cyc_chk("int_t5", idle_s, 1, 0, 0);
        cyc_chk("int_t6", idle_s, 0, 0, 0);
        idle_cycles(2);

        // Interrupt masked.
        s = irq_s;
        s.ifl = 1'b0;
        for (int i = 0; i < 5; i++) cyc_chk($sformatf("mask_t%0d", i), s, 0, 0, 0);
        idle_cycles(2);

        // Branch beats load-use and interrupt; interrupt taken once back in RUN.
        cyc_chk("prio_t0", combo_s, 1, 0, 0);
        cyc_chk("prio_t1", irq_s,   1, 0, 0);
        cyc_chk("prio_t2", irq_s,   0, 0, 0);
        cyc_chk("prio_t3", idle_s,  1, 1, 0);
        cyc_chk("prio_t4", idle_s,  1, 1, 0);
        cyc_chk("prio_t5", idle_s,  0, 1, 1);
        cyc_chk("prio_t6", idle_s,  1, 0, 0);
        cyc_chk("prio_t7", idle_s,  1, 0, 0);
        cyc_chk("prio_t8", idle_s,  0, 0, 0);
        idle_cycles(2);

        // Reset while draining aborts the entry.
        cyc_chk("rdr_t0", irq_s, 0, 0, 0);
        apply(idle_s);
        #1;
        chk4("rdr_t1_pre", 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk4("rdr_t1_rst", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk4("rdr_held", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc_chk($sformatf("rdr_after%0d", i), idle_s, 0, 0, 0);

        // Random traffic against the timeline model.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        busy_end = -1;
        lock_end = -1;
        for (int c = 0; c < MLEN; c++) begin
            m_nop[c] = 1'b0; m_stall[c] = 1'b0; m_int[c] = 1'b0;
        end
        for (int k = 0; k < NRAND; k++) begin
            s.dv  = ($urandom_range(0, 3) != 0);
            s.ux  = 1'($urandom_range(0, 1));
            s.uy  = 1'($urandom_range(0, 1));
            s.xa  = AW'($urandom_range(0, 3));
            s.ya  = AW'($urandom_range(0, 3));
            s.wr  = 1'($urandom_range(0, 1));
            s.sel = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
            s.wa  = AW'($urandom_range(0, 3));
            s.br  = ($urandom_range(0, 7) == 0);
            s.irq = ($urandom_range(0, 5) == 0);
            s.ifl = ($urandom_range(0, 3) != 0);
            do_rst = ($urandom_range(0, 59) == 0);
            apply(s);
            if (do_rst) rst_n = 1'b0;
            model_step(k, s, do_rst);
            @(negedge clk);
            chk($sformatf("rnd%0d.nop", k),      hz.nop,      m_nop[k]);
            chk($sformatf("rnd%0d.pc_stall", k), hz.pc_stall, m_stall[k]);
            chk($sformatf("rnd%0d.interupt", k), hz.interupt, m_int[k]);
            chk($sformatf("rnd%0d.intr_ack", k), hz.intr_ack, m_int[k]);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
